// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one backing-memory port between icache and dcache,
// round-robin with grant hold and an owner-tag FIFO for in-order read responses.
module mem_arbiter #(
    parameter int ADDR_BITS       = 28,
    parameter int DATA_BITS       = 128,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ic_req_valid,
    output logic                   ic_req_ready,
    input  logic [ADDR_BITS-1:0]   ic_req_addr,
    input  logic                   ic_req_rw,
    input  logic                   ic_req_data_valid,
    output logic                   ic_req_data_ready,
    input  logic [DATA_BITS-1:0]   ic_req_data_bits,
    input  logic [DATA_BITS/8-1:0] ic_req_data_mask,
    output logic                   ic_resp_valid,
    output logic [DATA_BITS-1:0]   ic_resp_data,
    input  logic                   dc_req_valid,
    output logic                   dc_req_ready,
    input  logic [ADDR_BITS-1:0]   dc_req_addr,
    input  logic                   dc_req_rw,
    input  logic                   dc_req_data_valid,
    output logic                   dc_req_data_ready,
    input  logic [DATA_BITS-1:0]   dc_req_data_bits,
    input  logic [DATA_BITS/8-1:0] dc_req_data_mask,
    output logic                   dc_resp_valid,
    output logic [DATA_BITS-1:0]   dc_resp_data,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [ADDR_BITS-1:0]   mem_req_addr,
    output logic                   mem_req_rw,
    output logic                   mem_req_data_valid,
    input  logic                   mem_req_data_ready,
    output logic [DATA_BITS-1:0]   mem_req_data_bits,
    output logic [DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic                   mem_resp_valid,
    input  logic [DATA_BITS-1:0]   mem_resp_data
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam logic [PW:0] MAX_CNT = (PW+1)'(MAX_OUTSTANDING);
    localparam logic IC = 1'b0;
    localparam logic DC = 1'b1;

    typedef enum logic [1:0] {ARB, HOLD, WDATA} state_t;

    state_t                 state_q, state_d;
    logic                   owner_q, owner_d, rr_q, rr_d;
    logic [MAX_OUTSTANDING-1:0] tag_q, tag_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]            count_q, count_d;
    logic                   ic_elig, dc_elig, sel, active, req_hs, data_hs, push, pop;
    logic                   s_valid, s_rw, s_dvalid;
    logic [ADDR_BITS-1:0]   s_addr;
    logic [DATA_BITS-1:0]   s_bits;
    logic [DATA_BITS/8-1:0] s_mask;

    always_comb begin
        ic_elig            = ic_req_valid & (ic_req_rw | (count_q < MAX_CNT));
        dc_elig            = dc_req_valid & (dc_req_rw | (count_q < MAX_CNT));
        sel                = (state_q == ARB) ? ((ic_elig & dc_elig) ? rr_q : dc_elig) : owner_q;
        // reset is active-low: every output is forced to zero while it is held
        active             = reset & ((state_q != ARB) | ic_elig | dc_elig);
        s_valid            = sel ? dc_req_valid : ic_req_valid;
        s_rw               = sel ? dc_req_rw : ic_req_rw;
        s_addr             = sel ? dc_req_addr : ic_req_addr;
        s_dvalid           = sel ? dc_req_data_valid : ic_req_data_valid;
        s_bits             = sel ? dc_req_data_bits : ic_req_data_bits;
        s_mask             = sel ? dc_req_data_mask : ic_req_data_mask;
        mem_req_valid      = active & (state_q != WDATA) & s_valid;
        mem_req_addr       = active ? s_addr : '0;
        mem_req_rw         = active & s_rw;
        mem_req_data_valid = active & s_dvalid;
        mem_req_data_bits  = active ? s_bits : '0;
        mem_req_data_mask  = active ? s_mask : '0;
        req_hs             = mem_req_valid & mem_req_ready;
        data_hs            = mem_req_data_valid & mem_req_data_ready;
        ic_req_ready       = req_hs & ~sel;
        dc_req_ready       = req_hs & sel;
        ic_req_data_ready  = active & mem_req_data_ready & ~sel;
        dc_req_data_ready  = active & mem_req_data_ready & sel;
        push               = req_hs & ~s_rw;
        pop                = reset & mem_resp_valid & (count_q != '0);
        ic_resp_valid      = pop & (tag_q[rd_ptr_q] == IC);
        dc_resp_valid      = pop & (tag_q[rd_ptr_q] == DC);
        ic_resp_data       = reset ? mem_resp_data : '0;
        dc_resp_data       = reset ? mem_resp_data : '0;
        tag_d              = tag_q;
        if (push)
            tag_d[wr_ptr_q] = sel;
        wr_ptr_d           = wr_ptr_q + PW'(push);
        rd_ptr_d           = rd_ptr_q + PW'(pop);
        count_d            = count_q + (PW+1)'(push) - (PW+1)'(pop);
        rr_d               = req_hs ? ~sel : rr_q;
        owner_d            = (state_q == WDATA) ? owner_q : sel;
        state_d            = (state_q == WDATA) ? (data_hs ? ARB : WDATA) :
                             req_hs ? ((s_rw & ~data_hs) ? WDATA : ARB) :
                             mem_req_valid ? HOLD : state_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ARB;
            owner_q  <= IC;
            rr_q     <= DC;
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
            tag_q    <= tag_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of grant order, grant hold, write-data phase,
// tag FIFO full/empty handling and reset behaviour of mem_arbiter.
module tb_mem_arbiter;
    logic         clk = 1'b0;
    logic         reset;
    logic         ic_req_valid, ic_req_ready, ic_req_rw, ic_req_data_valid, ic_req_data_ready, ic_resp_valid;
    logic [27:0]  ic_req_addr;
    logic [127:0] ic_req_data_bits, ic_resp_data;
    logic [15:0]  ic_req_data_mask;
    logic         dc_req_valid, dc_req_ready, dc_req_rw, dc_req_data_valid, dc_req_data_ready, dc_resp_valid;
    logic [27:0]  dc_req_addr;
    logic [127:0] dc_req_data_bits, dc_resp_data;
    logic [15:0]  dc_req_data_mask;
    logic         mem_req_valid, mem_req_ready, mem_req_rw, mem_req_data_valid, mem_req_data_ready, mem_resp_valid;
    logic [27:0]  mem_req_addr;
    logic [127:0] mem_req_data_bits, mem_resp_data;
    logic [15:0]  mem_req_data_mask;
    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
        .ic_req_rw(ic_req_rw), .ic_req_data_valid(ic_req_data_valid), .ic_req_data_ready(ic_req_data_ready),
        .ic_req_data_bits(ic_req_data_bits), .ic_req_data_mask(ic_req_data_mask),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
        .dc_req_rw(dc_req_rw), .dc_req_data_valid(dc_req_data_valid), .dc_req_data_ready(dc_req_data_ready),
        .dc_req_data_bits(dc_req_data_bits), .dc_req_data_mask(dc_req_data_mask),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_rw(mem_req_rw), .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b0;
        {ic_req_valid, ic_req_rw, ic_req_data_valid, dc_req_valid, dc_req_rw, dc_req_data_valid} = '0;
        {mem_req_ready, mem_req_data_ready, mem_resp_valid} = '0;
        ic_req_addr = '0; dc_req_addr = '0; mem_resp_data = '0;
        ic_req_data_bits = '0; dc_req_data_bits = '0; ic_req_data_mask = '0; dc_req_data_mask = '0;
        // reset: outputs forced low even with live inputs
        ic_req_valid = 1; ic_req_addr = 28'h5; mem_req_ready = 1; mem_resp_valid = 1; mem_resp_data = 128'h77;
        tick(); tick();
        #1;
        chk("rst_mem_valid", mem_req_valid, 0);
        chk("rst_ic_ready", ic_req_ready, 0);
        chk("rst_addr", mem_req_addr, 0);
        chk("rst_ic_resp", ic_resp_valid, 0);
        chk("rst_resp_data", ic_resp_data, 0);
        ic_req_valid = 0; ic_req_addr = 0; mem_resp_valid = 0; mem_resp_data = 0;
        #1 reset = 1'b1;
        tick();
        // 1) simultaneous reads: dc first (rr starts at DC), then ic
        ic_req_valid = 1; ic_req_addr = 28'h10; dc_req_valid = 1; dc_req_addr = 28'h20; mem_req_ready = 1;
        #1;
        chk("t1_addr0", mem_req_addr, 28'h20);
        chk("t1_dc_ready0", dc_req_ready, 1);
        chk("t1_ic_ready0", ic_req_ready, 0);
        tick();
        dc_req_valid = 0;
        #1;
        chk("t1_addr1", mem_req_addr, 28'h10);
        chk("t1_ic_ready1", ic_req_ready, 1);
        tick();
        ic_req_valid = 0; mem_resp_valid = 1; mem_resp_data = 128'hA;
        #1;
        chk("t1_idle", mem_req_valid, 0);
        chk("t1_dc_resp", dc_resp_valid, 1);
        chk("t1_ic_noresp", ic_resp_valid, 0);
        chk("t1_dc_data", dc_resp_data, 128'hA);
        tick();
        mem_resp_data = 128'hB;
        #1;
        chk("t1_ic_resp", ic_resp_valid, 1);
        chk("t1_dc_noresp", dc_resp_valid, 0);
        chk("t1_ic_data", ic_resp_data, 128'hB);
        tick();
        mem_resp_valid = 0;
        // 2) dc write whose data arrives three cycles late blocks an ic read
        dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 28'h30; mem_req_data_ready = 1;
        #1;
        chk("t2_dc_ready", dc_req_ready, 1);
        tick();
        dc_req_valid = 0; ic_req_valid = 1; ic_req_rw = 0; ic_req_addr = 28'h40;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("t2_wait_valid", mem_req_valid, 0);
            chk("t2_wait_ic_ready", ic_req_ready, 0);
            tick();
        end
        dc_req_data_valid = 1; dc_req_data_bits = 128'h55; dc_req_data_mask = 16'hFFFF;
        #1;
        chk("t2_dvalid", mem_req_data_valid, 1);
        chk("t2_dbits", mem_req_data_bits, 128'h55);
        chk("t2_dmask", mem_req_data_mask, 16'hFFFF);
        chk("t2_dc_dready", dc_req_data_ready, 1);
        chk("t2_ic_dready", ic_req_data_ready, 0);
        chk("t2_no_req", mem_req_valid, 0);
        tick();
        dc_req_data_valid = 0; dc_req_rw = 0;
        #1;
        chk("t2_ic_addr", mem_req_addr, 28'h40);
        chk("t2_ic_ready", ic_req_ready, 1);
        tick();
        ic_req_valid = 0; mem_resp_valid = 1; mem_resp_data = 128'hC;
        #1;
        chk("t2_ic_resp", ic_resp_valid, 1);
        tick();
        mem_resp_valid = 0;
        // 3) grant held by ic for five stalled cycles although dc is the rr favourite
        mem_req_ready = 0; ic_req_valid = 1; ic_req_addr = 28'h50;
        #1;
        chk("t3_addr0", mem_req_addr, 28'h50);
        chk("t3_ic_ready0", ic_req_ready, 0);
        tick();
        dc_req_valid = 1; dc_req_addr = 28'h60;
        for (int i = 1; i < 5; i++) begin
            #1;
            chk("t3_hold_addr", mem_req_addr, 28'h50);
            chk("t3_hold_ic_ready", ic_req_ready, 0);
            chk("t3_hold_dc_ready", dc_req_ready, 0);
            tick();
        end
        mem_req_ready = 1;
        #1;
        chk("t3_accept_ic", ic_req_ready, 1);
        chk("t3_accept_dc", dc_req_ready, 0);
        tick();
        ic_req_valid = 0;
        #1;
        chk("t3_dc_addr", mem_req_addr, 28'h60);
        chk("t3_dc_ready", dc_req_ready, 1);
        tick();
        dc_req_valid = 0; mem_resp_valid = 1; mem_resp_data = 128'h1;
        #1;
        chk("t3_resp_ic", ic_resp_valid, 1);
        tick();
        mem_resp_data = 128'h2;
        #1;
        chk("t3_resp_dc", dc_resp_valid, 1);
        tick();
        mem_resp_valid = 0;
        // 4) four dc reads fill the FIFO; fifth blocked, ic write still passes
        dc_req_valid = 1; dc_req_addr = 28'h70;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t4_fill_ready", dc_req_ready, 1);
            tick();
        end
        #1;
        chk("t4_full_valid", mem_req_valid, 0);
        chk("t4_full_dc_ready", dc_req_ready, 0);
        ic_req_valid = 1; ic_req_rw = 1; ic_req_addr = 28'h80;
        ic_req_data_valid = 1; ic_req_data_bits = 128'h99; ic_req_data_mask = 16'h00FF;
        #1;
        chk("t4_wr_valid", mem_req_valid, 1);
        chk("t4_wr_addr", mem_req_addr, 28'h80);
        chk("t4_wr_rw", mem_req_rw, 1);
        chk("t4_wr_ready", ic_req_ready, 1);
        chk("t4_wr_dready", ic_req_data_ready, 1);
        chk("t4_wr_dbits", mem_req_data_bits, 128'h99);
        tick();
        ic_req_valid = 0; ic_req_rw = 0; ic_req_data_valid = 0;
        mem_resp_valid = 1; mem_resp_data = 128'hD;
        #1;
        chk("t4_still_blocked", mem_req_valid, 0);
        chk("t4_resp_dc", dc_resp_valid, 1);
        tick();
        // 5) read accepted with a same-cycle response: count unchanged
        mem_resp_data = 128'hE;
        #1;
        chk("t5_granted", dc_req_ready, 1);
        chk("t5_resp_dc", dc_resp_valid, 1);
        chk("t5_resp_data", dc_resp_data, 128'hE);
        chk("t5_resp_ic", ic_resp_valid, 0);
        tick();
        dc_req_valid = 0;
        #1;
        chk("t5_count", dut.count_q, 3);
        for (int i = 0; i < 3; i++) begin
            chk("t5_drain", dc_resp_valid, 1);
            tick();
            #1;
        end
        chk("t5_empty_drop_dc", dc_resp_valid, 0);
        chk("t5_empty_drop_ic", ic_resp_valid, 0);
        tick();
        mem_resp_valid = 0;
        // 6) reset with two reads outstanding discards them
        ic_req_valid = 1; ic_req_addr = 28'h90;
        tick();
        ic_req_valid = 0; dc_req_valid = 1; dc_req_addr = 28'hA0;
        tick();
        dc_req_valid = 0;
        #1;
        chk("t6_count", dut.count_q, 2);
        ic_req_valid = 1; mem_resp_valid = 1; mem_resp_data = 128'hF;
        reset = 1'b0;
        #1;
        chk("t6_rst_valid", mem_req_valid, 0);
        chk("t6_rst_ic_ready", ic_req_ready, 0);
        chk("t6_rst_ic_resp", ic_resp_valid, 0);
        chk("t6_rst_dc_resp", dc_resp_valid, 0);
        chk("t6_rst_data", dc_resp_data, 0);
        tick();
        ic_req_valid = 0; reset = 1'b1;
        #1;
        chk("t6_post_ic_resp", ic_resp_valid, 0);
        chk("t6_post_dc_resp", dc_resp_valid, 0);
        chk("t6_post_data", ic_resp_data, 128'hF);
        tick();
        mem_resp_valid = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
